// File: rtl/matrix_slot_allocator.sv
// Slot allocator for the shared matrix storage RAM: grants base addresses for new
// matrices, tracks committed slots per (m, n) class and resolves (m, n, id) lookups.
module matrix_slot_allocator #(
    parameter int SLOTS  = 2,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_req,
    input  logic [2:0]        alloc_m,
    input  logic [2:0]        alloc_n,
    input  logic              alloc_commit,
    input  logic              alloc_abort,
    input  logic              lookup_req,
    input  logic [2:0]        lookup_m,
    input  logic [2:0]        lookup_n,
    input  logic [1:0]        lookup_id,
    output logic [ADDR_W-1:0] base_addr,
    output logic              addr_ready,
    output logic              lookup_done,
    output logic              lookup_hit,
    output logic [1:0]        class_count,
    output logic              dim_err,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, A_CALC, A_GRANT, A_WAIT, L_CALC, L_RESP} state_t;

    function automatic logic legal_dim(input logic [2:0] d);
        return (d >= 3'd1) && (d <= 3'd5);
    endfunction

    // Classes are packed m-major; each class holds SLOTS matrices of m*n words.
    function automatic logic [ADDR_W-1:0] slot_base(input logic [2:0] m, input logic [2:0] n,
                                                    input logic slot);
        int mi;
        int ni;
        int b;
        mi = int'(m);
        ni = int'(n);
        b  = SLOTS * (15 * ((mi - 1) * mi / 2) + mi * ((ni - 1) * ni / 2)) + int'(slot) * mi * ni;
        return ADDR_W'(b);
    endfunction

    function automatic logic [4:0] class_index(input logic [2:0] m, input logic [2:0] n);
        return 5'((int'(m) - 1) * 5 + int'(n) - 1);
    endfunction

    function automatic logic [1:0] popcount(input logic [SLOTS-1:0] v);
        logic [1:0] c;
        c = 2'd0;
        for (int i = 0; i < SLOTS; i++) c = c + {1'b0, v[i]};
        return c;
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic [2:0]       req_m_r;
    logic [2:0]       req_n_r;
    logic [1:0]       req_id_r;
    logic [SLOTS-1:0] valid_r [25];
    logic             wr_ptr_r [25];
    logic             slot_r;
    logic             ovw_r;

    logic             dims_ok_s;
    logic             lk_err_s;
    logic [4:0]       idx_s;
    logic [SLOTS-1:0] cls_valid_s;
    logic             free_found_s;
    logic             free_slot_s;
    logic             alloc_slot_s;
    logic             lk_slot_s;

    // Class decode, lowest-free-slot search and lookup error check on latched request.
    always_comb begin
        dims_ok_s    = legal_dim(req_m_r) && legal_dim(req_n_r);
        idx_s        = dims_ok_s ? class_index(req_m_r, req_n_r) : 5'd0;
        cls_valid_s  = valid_r[idx_s];
        free_found_s = 1'b0;
        free_slot_s  = 1'b0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            free_found_s = free_found_s | ~cls_valid_s[i];
            free_slot_s  = cls_valid_s[i] ? free_slot_s : 1'(i);
        end
        alloc_slot_s = free_found_s ? free_slot_s : wr_ptr_r[idx_s];
        lk_slot_s    = ~req_id_r[0];
        lk_err_s     = !dims_ok_s || (req_id_r == 2'd0) || (int'(req_id_r) > SLOTS);
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (alloc_req)       next_state_s = A_CALC;
                else if (lookup_req) next_state_s = L_CALC;
                else                 next_state_s = IDLE;
            end
            A_CALC:  next_state_s = dims_ok_s ? A_GRANT : IDLE;
            A_GRANT: next_state_s = A_WAIT;
            A_WAIT: begin
                if (alloc_abort || alloc_commit) next_state_s = IDLE;
                else                             next_state_s = A_WAIT;
            end
            L_CALC:  next_state_s = lk_err_s ? IDLE : L_RESP;
            L_RESP:  next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= next_state_s;
    end

    // Request capture and registered outputs; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_m_r     <= 3'd0;
            req_n_r     <= 3'd0;
            req_id_r    <= 2'd0;
            slot_r      <= 1'b0;
            ovw_r       <= 1'b0;
            base_addr   <= '0;
            addr_ready  <= 1'b0;
            lookup_done <= 1'b0;
            lookup_hit  <= 1'b0;
            class_count <= 2'd0;
            dim_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            addr_ready  <= 1'b0;
            lookup_done <= 1'b0;
            dim_err     <= 1'b0;
            busy        <= (next_state_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (alloc_req) begin
                        req_m_r <= alloc_m;
                        req_n_r <= alloc_n;
                        dim_err <= !(legal_dim(alloc_m) && legal_dim(alloc_n));
                    end else if (lookup_req) begin
                        req_m_r  <= lookup_m;
                        req_n_r  <= lookup_n;
                        req_id_r <= lookup_id;
                    end else begin
                        req_m_r <= req_m_r;
                    end
                end
                A_CALC: begin
                    if (dims_ok_s) begin
                        base_addr   <= slot_base(req_m_r, req_n_r, alloc_slot_s);
                        addr_ready  <= 1'b1;
                        slot_r      <= alloc_slot_s;
                        ovw_r       <= !free_found_s;
                        // Count reflects the chosen slot already invalidated.
                        class_count <= popcount(cls_valid_s & ~(SLOTS'(1) << alloc_slot_s));
                    end else begin
                        slot_r <= slot_r;
                    end
                end
                L_CALC: begin
                    lookup_done <= 1'b1;
                    if (lk_err_s) begin
                        dim_err    <= 1'b1;
                        lookup_hit <= 1'b0;
                    end else begin
                        base_addr   <= slot_base(req_m_r, req_n_r, lk_slot_s);
                        lookup_hit  <= cls_valid_s[lk_slot_s];
                        class_count <= popcount(cls_valid_s);
                    end
                end
                default: begin
                    slot_r <= slot_r;
                end
            endcase
        end
    end

    // Per-class valid bits and round-robin overwrite pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < 25; c++) begin
                valid_r[c]  <= '0;
                wr_ptr_r[c] <= 1'b0;
            end
        end else begin
            case (state_r)
                A_GRANT: valid_r[idx_s][slot_r] <= 1'b0;
                A_WAIT: begin
                    if (alloc_abort) begin
                        valid_r[idx_s][slot_r] <= 1'b0;
                    end else if (alloc_commit) begin
                        valid_r[idx_s][slot_r] <= 1'b1;
                        if (ovw_r) wr_ptr_r[idx_s] <= (SLOTS > 1) ? ~wr_ptr_r[idx_s] : 1'b0;
                        else       wr_ptr_r[idx_s] <= wr_ptr_r[idx_s];
                    end else begin
                        valid_r[idx_s][slot_r] <= valid_r[idx_s][slot_r];
                    end
                end
                default: begin
                    valid_r[idx_s] <= valid_r[idx_s];
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_slot_allocator.sv
// Directed bench for matrix_slot_allocator with hand-computed addresses and flags.
module tb_matrix_slot_allocator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alloc_req, alloc_commit, alloc_abort, lookup_req;
    logic [2:0] alloc_m, alloc_n, lookup_m, lookup_n;
    logic [1:0] lookup_id;
    logic [8:0] base_addr;
    logic       addr_ready, lookup_done, lookup_hit, dim_err, busy;
    logic [1:0] class_count;

    int errors = 0;
    int checks = 0;

    matrix_slot_allocator #(.SLOTS(2), .ADDR_W(9)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_m(alloc_m), .alloc_n(alloc_n),
        .alloc_commit(alloc_commit), .alloc_abort(alloc_abort),
        .lookup_req(lookup_req), .lookup_m(lookup_m), .lookup_n(lookup_n), .lookup_id(lookup_id),
        .base_addr(base_addr), .addr_ready(addr_ready), .lookup_done(lookup_done),
        .lookup_hit(lookup_hit), .class_count(class_count), .dim_err(dim_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Full allocation handshake; finish with commit (abort=0) or abort (abort=1).
    task automatic do_alloc(input string tag, input logic [2:0] m, input logic [2:0] n,
                            input int exp_base, input int exp_cc, input logic abort);
        alloc_m = m; alloc_n = n; alloc_req = 1'b1;
        tick();
        chk({tag, ".busy1"}, busy, 1);
        chk({tag, ".rdy1"}, addr_ready, 0);
        tick();
        chk({tag, ".rdy2"}, addr_ready, 1);
        chk({tag, ".base"}, base_addr, exp_base);
        chk({tag, ".cc"}, class_count, exp_cc);
        alloc_req = 1'b0;
        tick();
        chk({tag, ".rdy3"}, addr_ready, 0);
        chk({tag, ".base_hold"}, base_addr, exp_base);
        if (abort) alloc_abort = 1'b1;
        else       alloc_commit = 1'b1;
        tick();
        alloc_abort = 1'b0; alloc_commit = 1'b0;
        chk({tag, ".idle"}, busy, 0);
    endtask

    task automatic do_lookup(input string tag, input logic [2:0] m, input logic [2:0] n,
                             input logic [1:0] id, input logic exp_hit, input logic exp_err,
                             input int exp_base, input int exp_cc);
        lookup_m = m; lookup_n = n; lookup_id = id; lookup_req = 1'b1;
        tick();
        chk({tag, ".done1"}, lookup_done, 0);
        tick();
        chk({tag, ".done2"}, lookup_done, 1);
        chk({tag, ".hit"}, lookup_hit, exp_hit);
        chk({tag, ".err"}, dim_err, exp_err);
        if (!exp_err) begin
            chk({tag, ".base"}, base_addr, exp_base);
            chk({tag, ".cc"}, class_count, exp_cc);
        end
        lookup_req = 1'b0;
        tick();
        chk({tag, ".done3"}, lookup_done, 0);
    endtask

    initial begin
        rst_n = 1'b0; alloc_req = 1'b0; alloc_commit = 1'b0; alloc_abort = 1'b0;
        lookup_req = 1'b0; alloc_m = 3'd0; alloc_n = 3'd0;
        lookup_m = 3'd0; lookup_n = 3'd0; lookup_id = 2'd0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst.base", base_addr, 0);
        chk("rst.outs", {addr_ready, lookup_done, lookup_hit, class_count, dim_err, busy}, 0);

        // 1: two fresh allocations in (2,3), then lookup id 2
        do_alloc("t1a", 3'd2, 3'd3, 42, 0, 1'b0);
        do_alloc("t1b", 3'd2, 3'd3, 48, 1, 1'b0);
        do_lookup("t1l", 3'd2, 3'd3, 2'd2, 1'b1, 1'b0, 48, 2);

        // 2: full class overwrites round-robin; aborted overwrite leaves slot empty
        do_alloc("t2a", 3'd2, 3'd3, 42, 1, 1'b0);
        do_alloc("t2b", 3'd2, 3'd3, 48, 1, 1'b0);
        do_alloc("t2c", 3'd2, 3'd3, 42, 1, 1'b0);
        do_lookup("t2l1", 3'd2, 3'd3, 2'd1, 1'b1, 1'b0, 42, 2);
        do_alloc("t2d", 3'd2, 3'd3, 48, 1, 1'b1);
        do_lookup("t2l2", 3'd2, 3'd3, 2'd2, 1'b0, 1'b0, 48, 1);
        do_alloc("t2e", 3'd2, 3'd3, 48, 1, 1'b0);
        do_lookup("t2l3", 3'd2, 3'd3, 2'd2, 1'b1, 1'b0, 48, 2);

        // 3: abort in (5,5), then reallocate same base
        do_alloc("t3a", 3'd5, 3'd5, 400, 0, 1'b1);
        do_lookup("t3l", 3'd5, 3'd5, 2'd1, 1'b0, 1'b0, 400, 0);
        do_alloc("t3b", 3'd5, 3'd5, 400, 0, 1'b0);
        do_lookup("t3l2", 3'd5, 3'd5, 2'd2, 1'b0, 1'b0, 425, 1);

        // 4: illegal dimensions and id
        alloc_m = 3'd6; alloc_n = 3'd2; alloc_req = 1'b1;
        tick();
        chk("t4.err1", dim_err, 1);
        alloc_req = 1'b0;
        tick();
        chk("t4.rdy", addr_ready, 0);
        chk("t4.err2", dim_err, 0);
        chk("t4.busy", busy, 0);
        do_lookup("t4l", 3'd2, 3'd3, 2'd3, 1'b0, 1'b1, 0, 0);

        // 5: simultaneous requests: alloc first, lookup 2 cycles after IDLE
        alloc_m = 3'd1; alloc_n = 3'd1; lookup_m = 3'd1; lookup_n = 3'd1; lookup_id = 2'd1;
        alloc_req = 1'b1; lookup_req = 1'b1;
        tick();
        tick();
        chk("t5.rdy", addr_ready, 1);
        chk("t5.base", base_addr, 0);
        chk("t5.ldone", lookup_done, 0);
        alloc_req = 1'b0;
        tick();
        alloc_commit = 1'b1;
        tick();
        alloc_commit = 1'b0;
        chk("t5.idle", busy, 0);
        tick();
        chk("t5.done1", lookup_done, 0);
        tick();
        chk("t5.done2", lookup_done, 1);
        chk("t5.hit", lookup_hit, 1);
        chk("t5.cc", class_count, 1);
        lookup_req = 1'b0;
        tick();

        // 6: reset during A_WAIT empties everything
        alloc_m = 3'd1; alloc_n = 3'd1; alloc_req = 1'b1;
        tick(); tick();
        chk("t6.base", base_addr, 1);
        alloc_req = 1'b0;
        tick();
        chk("t6.wait", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6.base0", base_addr, 0);
        chk("t6.outs", {addr_ready, lookup_done, lookup_hit, class_count, dim_err, busy}, 0);
        tick();
        chk("t6.idle", busy, 0);
        do_lookup("t6l1", 3'd1, 3'd1, 2'd1, 1'b0, 1'b0, 0, 0);
        do_lookup("t6l2", 3'd2, 3'd3, 2'd2, 1'b0, 1'b0, 48, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
